sixtyfour_bit_serial_subtractor: RTL and testbench



---
 rtl/sixtyfour_bit_serial_subtractor.sv | 102 ++++++++++
 tb/tb_sixtyfour_bit_serial_subtractor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sixtyfour_bit_serial_subtractor.sv
// 64-bit serial subtractor: diff = a - b - b_in, computed as a + ~b + ~b_in
// through one 16-bit slice reused over four cycles, LSB slice first.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds a/b/b_in stable while in_valid is high and
// in_ready is low; the block holds diff/b_out/ovf stable while out_valid is
// high and out_ready is low. in_ready is high only in IDLE and out_valid
// only in DONE, so the two handshakes never complete on the same edge.
module sixtyfour_bit_serial_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        b_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] diff,
  output logic        b_out,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] a_r;
  logic [63:0] b_r;
  logic        c;        // active-high carry; a borrow is ~c
  logic [1:0]  cnt;      // slice index while in CALC

  logic [5:0]  slice_base;
  logic [15:0] a_slice;
  logic [15:0] b_slice;
  logic [16:0] slice_sum;

  // Select the current 16-bit slice and add it with the inverted subtrahend.
  always_comb begin
    slice_base = {cnt, 4'b0000};
    a_slice    = a_r[slice_base +: 16];
    b_slice    = b_r[slice_base +: 16];
    slice_sum  = {1'b0, a_slice} + {1'b0, ~b_slice} + {16'b0, c};
  end

  // Control FSM plus operand, carry and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= 64'd0;
      b_out     <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= 2'd0;
      c         <= 1'b0;
      a_r       <= 64'd0;
      b_r       <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            c        <= ~b_in;
            cnt      <= 2'd0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          diff[slice_base +: 16] <= slice_sum[15:0];
          c                      <= slice_sum[16];
          cnt                    <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            // slice_sum[15] is the final diff[63] written on this edge.
            b_out     <= ~slice_sum[16];
            ovf       <= (a_r[63] != b_r[63]) && (slice_sum[15] != a_r[63]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sixtyfour_bit_serial_subtractor.sv
// Bench for sixtyfour_bit_serial_subtractor: directed cases, backpressure,
// mid-operation reset and a long randomized run against an arithmetic model.
module tb_sixtyfour_bit_serial_subtractor;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        b_in;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] diff;
  logic        b_out;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  sixtyfour_bit_serial_subtractor dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .b_out     (b_out),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on the full operands.
  task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic mbin,
                       output logic [63:0] ed, output logic eb, output logic eo);
    logic [64:0] need;
    logic signed [65:0] sres;
    ed   = ma - mb - {63'd0, mbin};
    need = {1'b0, mb} + {64'd0, mbin};
    eb   = ({1'b0, ma} < need);
    sres = $signed({{2{ma[63]}}, ma}) - $signed({{2{mb[63]}}, mb}) - $signed({65'd0, mbin});
    eo   = (sres > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (sres < -66'sh0_8000_0000_0000_0000);
  endtask

  // Present operands, wait for the result, check it, then hold out_ready low
  // for ready_delay cycles before completing the result handshake.
  task automatic run_op(input string tag, input logic [63:0] oa, input logic [63:0] ob,
                        input logic obin, input int ready_delay);
    logic [63:0] ed;
    logic        eb;
    logic        eo;
    int          cyc;
    model(oa, ob, obin, ed, eb, eo);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    a        = oa;
    b        = ob;
    b_in     = obin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = $urandom();
    b        = $urandom();
    b_in     = $urandom_range(0, 1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd4);
    check({tag, "_diff"},    diff, ed);
    check({tag, "_b_out"},   {63'd0, b_out}, {63'd0, eb});
    check({tag, "_ovf"},     {63'd0, ovf},   {63'd0, eo});
    for (int i = 0; i < ready_delay; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_done_ov"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_done_ir"}, {63'd0, in_ready},  64'd1);
  endtask

  initial begin
    logic [63:0] ed;
    logic        eb;
    logic        eo;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rbin;

    rst       = 1'b1;
    a         = 64'hDEAD_BEEF_0000_1111;
    b         = 64'h1;
    b_in      = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;

    // Reset with in_valid asserted must not start an operation.
    tick();
    tick();
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_diff",      diff, 64'd0);
    check("rst_b_out",     {63'd0, b_out}, 64'd0);
    check("rst_ovf",       {63'd0, ovf},   64'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();

    // Directed corner cases.
    run_op("zero_borrow", 64'd0, 64'd0, 1'b1, 0);
    check("zero_borrow_const", diff, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("large_b0", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1);
    check("large_b0_const", diff, 64'd1);
    run_op("large_b1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 0);
    check("large_b1_const", diff, 64'd0);
    run_op("small_wrap", 64'h11, 64'h12, 1'b0, 2);
    check("small_wrap_const", diff, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("cross_slice", 64'h0000_0001_0000_0000, 64'd1, 1'b0, 0);
    check("cross_slice_const", diff, 64'h0000_0000_FFFF_FFFF);
    run_op("signed_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 0);
    check("signed_ovf_const", {62'd0, ovf, b_out}, 64'd2);

    // Backpressure: result stays stable and new operands are ignored.
    model(64'h124552, 64'h47264, 1'b1, ed, eb, eo);
    a        = 64'h124552;
    b        = 64'h47264;
    b_in     = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("bp_out_valid0", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a        = {$urandom(), $urandom()};
      b        = {$urandom(), $urandom()};
      b_in     = $urandom_range(0, 1);
      tick();
      check("bp_diff",      diff, ed);
      check("bp_b_out",     {63'd0, b_out},     {63'd0, eb});
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready",  {63'd0, in_ready},  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_ir", {63'd0, in_ready},  64'd1);
    check("bp_release_ov", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 6; i++) tick();
    check("bp_no_second_op", {63'd0, out_valid}, 64'd0);

    // Reset two cycles after acceptance discards the operation.
    a        = 64'hFFFF_0000_FFFF_0000;
    b        = 64'h0000_FFFF_0000_FFFF;
    b_in     = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    check("midrst_diff",      diff, 64'd0);
    for (int i = 0; i < 5; i++) tick();
    check("midrst_no_result", {63'd0, out_valid}, 64'd0);
    run_op("after_rst", 64'h12, 64'h11, 1'b1, 0);
    check("after_rst_const", {diff[62:0], b_out}, 64'd0);

    // Randomized operations with random idle gaps and result backpressure.
    for (int n = 0; n < 1000; n++) begin
      ra   = {$urandom(), $urandom()};
      rb   = {$urandom(), $urandom()};
      rbin = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rb = ~ra;
        2: ra = 64'd0;
        3: ra = {ra[63], 63'd0};
        default: ;
      endcase
      for (int g = 0; g < $urandom_range(0, 3); g++) tick();
      run_op("rand", ra, rb, rbin, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
